de_pair_serializer: RTL and testbench

- Consumer (DE side) of the RE→DE pipeline register; takes registered 8-bit D/Q value pairs and drives the stall back to it.
- Buffers pairs in a small FIFO and emits them as a byte stream (D first, then Q) on a valid/ready interface to downstream logic.
- Asserts stall upstream when the FIFO is full so no pair is lost under downstream back-pressure.

---
 rtl/de_pair_serializer.sv | 152 +++++++++++++++
 tb/tb_de_pair_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de_pair_serializer.sv
// ============================================================================
// Module   : de_pair_serializer
// Purpose  : DE-side consumer of the RE->DE pipeline register. Buffers 8-bit
//            D/Q pairs in a small FIFO and emits them as a byte stream
//            (D first, then Q) on a valid/ready interface. Stalls upstream
//            when the FIFO is full so no pair is lost to back-pressure.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_clk        in   1  clock, rising edge
//   i_rst_n      in   1  asynchronous active-low reset
//   i_valid      in   1  incoming pair valid
//   i_D_value    in   8  D value of incoming pair
//   i_Q_value    in   8  Q value of incoming pair
//   o_stall      out  1  hold request to upstream register (FIFO full)
//   o_data       out  8  serialized byte
//   o_valid      out  1  o_data valid
//   o_is_q       out  1  0 = o_data is D, 1 = o_data is Q
//   i_ready      in   1  downstream accepts when o_valid && i_ready
//   o_overflow   out  1  sticky: a pair arrived while stalled
//   o_pair_count out 16  pairs popped, wraps (only with DE_PAIR_COUNT_EN)
// Configuration macro:
//   DE_PAIR_COUNT_EN - adds the o_pair_count output and its counter.
// ============================================================================
`default_nettype none

module de_pair_serializer #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_D_value,
  input  logic [7:0]  i_Q_value,
  output logic        o_stall,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_is_q,
  input  logic        i_ready,
  output logic        o_overflow
`ifdef DE_PAIR_COUNT_EN
  ,
  output logic [15:0] o_pair_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND_D = 2'd1,
    S_SEND_Q = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]         d_mem_q [DEPTH];
  logic [7:0]         q_mem_q [DEPTH];
  logic               overflow_q;
  logic               push, pop;

  // Stall depends only on the registered count, so a pop in the same cycle
  // cannot release it until the following cycle.
  assign o_stall    = (count_q == CNT_W'(DEPTH));
  assign push       = i_valid && !o_stall;
  assign pop        = (state_q == S_SEND_Q) && i_ready;
  assign o_overflow = overflow_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      d_mem_q[wr_ptr_q] <= i_D_value;
      q_mem_q[wr_ptr_q] <= i_Q_value;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (i_valid && o_stall) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (count_q != '0) state_q <= S_SEND_D;
        S_SEND_D: if (i_ready) state_q <= S_SEND_Q;
        S_SEND_Q: begin
          // A same-cycle push keeps the stream going without an IDLE bubble.
          if (i_ready) state_q <= (count_q > CNT_W'(1) || push) ? S_SEND_D : S_IDLE;
        end
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode only registered state and storage; i_ready never reaches
  // them combinationally, so they hold steady while waiting for a handshake.
  always_comb begin
    o_valid = 1'b0;
    o_is_q  = 1'b0;
    o_data  = 8'h00;
    case (state_q)
      S_SEND_D: begin
        o_valid = 1'b1;
        o_data  = d_mem_q[rd_ptr_q];
      end
      S_SEND_Q: begin
        o_valid = 1'b1;
        o_is_q  = 1'b1;
        o_data  = q_mem_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

`ifdef DE_PAIR_COUNT_EN
  logic [15:0] pair_count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  pair_count_q <= 16'h0000;
    else if (pop)  pair_count_q <= pair_count_q + 16'd1;
  end

  assign o_pair_count = pair_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_de_pair_serializer.sv
// ============================================================================
// Module   : tb_de_pair_serializer
// Purpose  : Self-checking bench for de_pair_serializer. A queue-based
//            reference model tracks buffered pairs and the byte being offered;
//            directed scenarios plus randomized traffic are compared per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_de_pair_serializer;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_D_value = 8'h00;
  logic [7:0]  i_Q_value = 8'h00;
  logic        i_ready = 1'b0;
  logic        o_stall;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_is_q;
  logic        o_overflow;
`ifdef DE_PAIR_COUNT_EN
  logic [15:0] o_pair_count;
`endif

  de_pair_serializer #(.DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_D_value    (i_D_value),
    .i_Q_value    (i_Q_value),
    .o_stall      (o_stall),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_is_q       (o_is_q),
    .i_ready      (i_ready),
    .o_overflow   (o_overflow)
`ifdef DE_PAIR_COUNT_EN
    ,
    .o_pair_count (o_pair_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents as {D,Q}, and which byte is on offer
  // (0 = nothing, 1 = head D, 2 = head Q).
  logic [15:0] m_q[$];
  int          m_ph;
  bit          m_ovf;
  logic [15:0] m_pc;

  logic [7:0]  acc_log[$];
  int          bubbles;
  bit          seen_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ph  = 0;
    m_ovf = 1'b0;
    m_pc  = 16'h0000;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input logic [7:0] q, input bit r);
    bit full, pu, po;
    int nph;
    full = (m_q.size() == DEPTH);
    pu   = v && !full;
    po   = (m_ph == 2) && r;
    nph  = m_ph;
    if (v && full) m_ovf = 1'b1;
    case (m_ph)
      0: if (m_q.size() != 0) nph = 1;
      1: if (r) nph = 2;
      2: if (r) nph = (m_q.size() > 1 || pu) ? 1 : 0;
      default: nph = 0;
    endcase
    if (po) begin
      void'(m_q.pop_front());
      m_pc = m_pc + 16'd1;
    end
    if (pu) m_q.push_back({d, q});
    m_ph = nph;
  endtask

  task automatic compare_outputs();
    logic [7:0] ed;
    ed = 8'h00;
    if (m_q.size() != 0) begin
      if (m_ph == 1) ed = m_q[0][15:8];
      if (m_ph == 2) ed = m_q[0][7:0];
    end
    chk("o_valid",    32'(o_valid),    32'(m_ph != 0));
    chk("o_is_q",     32'(o_is_q),     32'(m_ph == 2));
    chk("o_data",     32'(o_data),     32'(ed));
    chk("o_stall",    32'(o_stall),    32'(m_q.size() == DEPTH));
    chk("o_overflow", 32'(o_overflow), 32'(m_ovf));
`ifdef DE_PAIR_COUNT_EN
    chk("o_pair_count", 32'(o_pair_count), 32'(m_pc));
`endif
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, update the
  // model, then compare at the next falling edge.
  task automatic step(input bit v, input logic [7:0] d, input logic [7:0] q, input bit r);
    logic       pv, pq;
    logic [7:0] pd;
    i_valid   = v;
    i_D_value = d;
    i_Q_value = q;
    i_ready   = r;
    pv = o_valid;
    pd = o_data;
    pq = o_is_q;
    if (pv && r) acc_log.push_back(pd);
    if (seen_valid && !pv && m_q.size() != 0) bubbles++;
    if (pv) seen_valid = 1'b1;
    @(posedge i_clk);
    model_edge(v, d, q, r);
    @(negedge i_clk);
    compare_outputs();
    if (pv && !r) begin
      chk("hold_valid", 32'(o_valid), 32'(1));
      chk("hold_data",  32'(o_data),  32'(pd));
      chk("hold_is_q",  32'(o_is_q),  32'(pq));
    end
  endtask

  logic [7:0]  exp3 [8];
  logic [15:0] pairs4 [8];
  logic [7:0]  exp5[$];
  int          idx, guard;

  initial begin
    exp3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    model_reset();
    seen_valid = 1'b0;
    bubbles    = 0;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_data",  32'(o_data),  32'(8'h00));
    chk("rst_is_q",  32'(o_is_q),  32'(0));
    chk("rst_stall", 32'(o_stall), 32'(0));
    chk("rst_ovf",   32'(o_overflow), 32'(0));
    i_rst_n = 1'b1;

    // Single pair with ready held high
    acc_log.delete();
    step(1'b1, 8'hA5, 8'h3C, 1'b1);
    repeat (4) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("t1_len", 32'(acc_log.size()), 32'(2));
    if (acc_log.size() == 2) begin
      chk("t1_b0", 32'(acc_log[0]), 32'(8'hA5));
      chk("t1_b1", 32'(acc_log[1]), 32'(8'h3C));
    end

    // Fill the FIFO with downstream stalled
    step(1'b1, 8'h11, 8'h22, 1'b0);
    step(1'b1, 8'h33, 8'h44, 1'b0);
    step(1'b1, 8'h55, 8'h66, 1'b0);
    step(1'b1, 8'h77, 8'h88, 1'b0);
    chk("t2_stall", 32'(o_stall),    32'(1));
    chk("t2_data",  32'(o_data),     32'(8'h11));
    chk("t2_ovf",   32'(o_overflow), 32'(0));

    // Dropped pair while full, then drain
    step(1'b1, 8'h99, 8'hAA, 1'b0);
    chk("t3_ovf",   32'(o_overflow), 32'(1));
    chk("t3_stall", 32'(o_stall),    32'(1));
    acc_log.delete();
    repeat (12) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("t3_ovf_sticky", 32'(o_overflow), 32'(1));
    chk("t3_len", 32'(acc_log.size()), 32'(8));
    for (int i = 0; i < 8 && i < acc_log.size(); i++)
      chk("t3_byte", 32'(acc_log[i]), 32'(exp3[i]));

    // Back-to-back stream honouring stall
    for (int i = 0; i < 8; i++) pairs4[i] = 16'($urandom);
    acc_log.delete();
    bubbles    = 0;
    seen_valid = 1'b0;
    idx   = 0;
    guard = 0;
    while (idx < 8 && guard < 100) begin
      if (m_q.size() != DEPTH) begin
        step(1'b1, pairs4[idx][15:8], pairs4[idx][7:0], 1'b1);
        idx++;
      end else begin
        step(1'b0, 8'h00, 8'h00, 1'b1);
      end
      guard++;
    end
    chk("t4_pushed", 32'(idx), 32'(8));
    repeat (12) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("t4_len", 32'(acc_log.size()), 32'(16));
    for (int i = 0; i < 8 && 2 * i + 1 < acc_log.size(); i++) begin
      chk("t4_d", 32'(acc_log[2*i]),   32'(pairs4[i][15:8]));
      chk("t4_q", 32'(acc_log[2*i+1]), 32'(pairs4[i][7:0]));
    end
    chk("t4_bubbles", 32'(bubbles), 32'(0));

    // Ready toggling every cycle
    acc_log.delete();
    exp5.delete();
    for (int c = 0; c < 40; c++) begin
      logic [7:0] d, q;
      bit v;
      d = 8'($urandom);
      q = 8'($urandom);
      v = (c < 24) && (m_q.size() != DEPTH) && ($urandom_range(0, 1) == 1);
      if (v) begin
        exp5.push_back(d);
        exp5.push_back(q);
      end
      step(v, d, q, c[0]);
    end
    repeat (20) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("t5_len", 32'(acc_log.size()), 32'(exp5.size()));
    for (int i = 0; i < exp5.size() && i < acc_log.size(); i++)
      chk("t5_byte", 32'(acc_log[i]), 32'(exp5[i]));

    // Randomized traffic, including pairs offered while stalled
    for (int c = 0; c < 300; c++)
      step(1'(($urandom_range(0, 1))), 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);

    // Asynchronous reset while in the Q phase with 3 pairs buffered
    repeat (12) step(1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b1, 8'h01, 8'h02, 1'b0);
    step(1'b1, 8'h03, 8'h04, 1'b0);
    step(1'b1, 8'h05, 8'h06, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("t6_in_q", 32'(o_is_q), 32'(1));
    i_ready = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(o_valid),    32'(0));
    chk("t6_is_q",  32'(o_is_q),     32'(0));
    chk("t6_data",  32'(o_data),     32'(8'h00));
    chk("t6_stall", 32'(o_stall),    32'(0));
    chk("t6_ovf",   32'(o_overflow), 32'(0));
`ifdef DE_PAIR_COUNT_EN
    chk("t6_pc",    32'(o_pair_count), 32'(0));
`endif
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    acc_log.delete();
    repeat (3) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("t6_idle_len", 32'(acc_log.size()), 32'(0));
    step(1'b1, 8'hC3, 8'h5A, 1'b1);
    repeat (4) step(1'b0, 8'h00, 8'h00, 1'b1);
    chk("t6_len", 32'(acc_log.size()), 32'(2));
    if (acc_log.size() == 2) begin
      chk("t6_b0", 32'(acc_log[0]), 32'(8'hC3));
      chk("t6_b1", 32'(acc_log[1]), 32'(8'h5A));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
